// File: rtl/axis_frame_monitor.sv
// Passive AXI4-Stream observer: per-frame beat/byte counts, last-frame length latch,
// frame counter, and sticky over-length / master-stability error flags.
module axis_frame_monitor #(
  parameter int unsigned DSIZE     = 32,
  parameter int unsigned KSIZE     = (DSIZE / 8 > 0) ? DSIZE / 8 : 1,
  parameter int unsigned USIZE     = 1,
  parameter int unsigned CSIZE     = 32,
  parameter int unsigned FCSIZE    = 32,
  parameter int unsigned MAX_BEATS = 0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              aclken,
  input  logic              clear,
  input  logic [DSIZE-1:0]  axis_tdata,
  input  logic              axis_tvalid,
  input  logic              axis_tready,
  input  logic [USIZE-1:0]  axis_tuser,
  input  logic              axis_tlast,
  input  logic [KSIZE-1:0]  axis_tkeep,
  output logic [CSIZE-1:0]  beat_cnt,
  output logic [CSIZE-1:0]  byte_cnt,
  output logic              in_frame,
  output logic [CSIZE-1:0]  frame_len,
  output logic [CSIZE-1:0]  frame_bytes,
  output logic              frame_done,
  output logic [FCSIZE-1:0] frame_cnt,
  output logic              err_overlen,
  output logic              err_proto
);

  localparam int unsigned PSIZE = DSIZE + USIZE + 1 + KSIZE;
  localparam logic [CSIZE:0] MaxBeats = (CSIZE + 1)'(MAX_BEATS);

  logic [CSIZE-1:0]  beat_cnt_q, beat_cnt_d, byte_cnt_q, byte_cnt_d;
  logic [CSIZE-1:0]  frame_len_q, frame_len_d, frame_bytes_q, frame_bytes_d;
  logic [FCSIZE-1:0] frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              err_overlen_q, err_overlen_d, err_proto_q, err_proto_d;
  logic              stalled_q, stalled_d;
  logic [PSIZE-1:0]  rec_q, rec_d;

  logic [CSIZE-1:0]  keep_bytes;
  logic [CSIZE-1:0]  beat_inc, byte_inc;
  logic [CSIZE:0]    byte_sum;
  logic [PSIZE-1:0]  payload;
  logic              hs, stall, overlen_hit;

  always_comb begin
    keep_bytes = '0;
    for (int unsigned i = 0; i < KSIZE; i++) begin
      keep_bytes = keep_bytes + CSIZE'(axis_tkeep[i]);
    end
  end

  assign hs      = aclken & axis_tvalid & axis_tready;
  assign stall   = aclken & axis_tvalid & ~axis_tready;
  assign payload = {axis_tdata, axis_tuser, axis_tlast, axis_tkeep};

  // Saturating increments: counters stick at all-ones rather than wrapping.
  assign beat_inc = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CSIZE'(1);
  assign byte_sum = {1'b0, byte_cnt_q} + {1'b0, keep_bytes};
  assign byte_inc = byte_sum[CSIZE] ? '1 : byte_sum[CSIZE-1:0];

  // beat_cnt + 1 > MAX_BEATS, evaluated one bit wider to avoid overflow.
  assign overlen_hit = (MAX_BEATS != 0) && ({1'b0, beat_cnt_q} >= MaxBeats);

  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    frame_len_d   = frame_len_q;
    frame_bytes_d = frame_bytes_q;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
    err_overlen_d = err_overlen_q;
    err_proto_d   = err_proto_q;
    stalled_d     = stalled_q;
    rec_d         = rec_q;
    if (aclken) begin
      if (clear) begin
        beat_cnt_d    = '0;
        byte_cnt_d    = '0;
        frame_len_d   = '0;
        frame_bytes_d = '0;
        frame_cnt_d   = '0;
        err_overlen_d = 1'b0;
        err_proto_d   = 1'b0;
        stalled_d     = 1'b0;
        rec_d         = '0;
      end else begin
        if (hs) begin
          if (overlen_hit) err_overlen_d = 1'b1;
          if (axis_tlast) begin
            beat_cnt_d    = '0;
            byte_cnt_d    = '0;
            frame_len_d   = beat_inc;
            frame_bytes_d = byte_inc;
            frame_cnt_d   = frame_cnt_q + FCSIZE'(1);
            frame_done_d  = 1'b1;
          end else begin
            beat_cnt_d = beat_inc;
            byte_cnt_d = byte_inc;
          end
        end
        if (stalled_q && (!axis_tvalid || (payload != rec_q))) err_proto_d = 1'b1;
        stalled_d = stall;
        rec_d     = stall ? payload : '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      frame_len_q   <= '0;
      frame_bytes_q <= '0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      err_overlen_q <= 1'b0;
      err_proto_q   <= 1'b0;
      stalled_q     <= 1'b0;
      rec_q         <= '0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      frame_len_q   <= frame_len_d;
      frame_bytes_q <= frame_bytes_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_done_q  <= frame_done_d;
      err_overlen_q <= err_overlen_d;
      err_proto_q   <= err_proto_d;
      stalled_q     <= stalled_d;
      rec_q         <= rec_d;
    end
  end

  assign beat_cnt    = beat_cnt_q;
  assign byte_cnt    = byte_cnt_q;
  assign in_frame    = (beat_cnt_q != '0);
  assign frame_len   = frame_len_q;
  assign frame_bytes = frame_bytes_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_overlen = err_overlen_q;
  assign err_proto   = err_proto_q;

endmodule
